// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, reads the instruction
// BRAM (one-cycle read latency), presents each instruction to decode under a
// valid/ready handshake, then waits for the memory stage to return the next
// PC before fetching again. Keeps a retired-instruction count and a sticky
// misalignment error for debug.
module fetch_unit #(
  parameter int                   INST_SIZE = 10,
  parameter logic [INST_SIZE-1:0] INIT_PC   = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic [INST_SIZE-3:0] imem_addr,
  input  logic [31:0]          imem_dout,
  output logic [31:0]          inst,
  output logic [INST_SIZE-1:0] pc_out,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  input  logic                 npc_valid,
  input  logic [INST_SIZE-1:0] npc,
  output logic [31:0]          retired,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_EXEC,
    S_HALT
  } state_t;

  state_t               state;
  logic [INST_SIZE-1:0] pc;

  // The BRAM address is a pure slice of the PC register, so it is stable for
  // the whole FETCH cycle and changes only on the edge that loads a new PC.
  assign imem_addr = pc[INST_SIZE-1:2];

  // Fetch sequencer: state, PC, the decode-facing instruction register and
  // the debug counters all update together on the rising edge.
  always_ff @(posedge clk) begin
    // NOTE: every register here is state, so every assignment is non-blocking;
    // a blocking assignment would let later lines see the new value this edge.
    if (!rstn) begin
      state      <= S_IDLE;
      pc         <= INIT_PC;
      inst       <= '0;
      pc_out     <= '0;
      inst_valid <= 1'b0;
      retired    <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end

        // Address has been on the BRAM port for this cycle; data arrives next.
        S_FETCH: begin
          state <= S_WAIT;
        end

        // BRAM output is valid now: capture it alongside the PC it came from.
        S_WAIT: begin
          inst       <= imem_dout;
          pc_out     <= pc;
          inst_valid <= 1'b1;
          state      <= S_VALID;
        end

        // Hold inst/pc_out untouched until decode takes them.
        S_VALID: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= S_EXEC;
          end
        end

        // Wait for the downstream next-PC; a misaligned target is fatal.
        S_EXEC: begin
          if (npc_valid) begin
            if (npc[1:0] == 2'b00) begin
              pc      <= npc;
              retired <= retired + 32'd1;
              state   <= S_FETCH;
            end else begin
              err   <= 1'b1;
              state <= S_HALT;
            end
          end
        end

        // Terminal until reset.
        S_HALT: begin
          state <= S_HALT;
        end

        // NOTE: the explicit default recovers from an unused encoding of the
        // 3-bit state register instead of leaving the machine stuck there.
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of hand-derived vectors, a few
// directed multi-cycle sequences, and a randomized run compared cycle by cycle
// against a transaction-level reference model built from latency counts.
module tb_fetch_unit;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] inst;
  logic [9:0]  pc_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        npc_valid;
  logic [9:0]  npc;
  logic [31:0] retired;
  logic        err;

  fetch_unit #(.INST_SIZE(10), .INIT_PC(10'd0)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_dout  (imem_dout),
    .inst       (inst),
    .pc_out     (pc_out),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .npc_valid  (npc_valid),
    .npc        (npc),
    .retired    (retired),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction BRAM with one-cycle read latency.
  logic [31:0] mem [256];
  always @(posedge clk) imem_dout <= mem[imem_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the architectural view: current PC, what decode should see, and
  // how many edges remain until the next instruction becomes visible.
  logic [9:0]  m_pc;
  logic [31:0] m_inst;
  logic [9:0]  m_pcout;
  logic [31:0] m_ret;
  logic        m_err;
  logic        m_valid;
  logic        m_await;
  logic        m_halt;
  logic        m_idle;
  int          m_cnt;

  task automatic model_update(input logic r, s, rd, nv, input logic [9:0] n);
    if (!r) begin
      m_pc = 10'd0; m_inst = 32'd0; m_pcout = 10'd0; m_ret = 32'd0; m_err = 1'b0;
      m_valid = 1'b0; m_await = 1'b0; m_halt = 1'b0; m_idle = 1'b1; m_cnt = 0;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (m_idle) begin
      if (s) begin m_idle = 1'b0; m_cnt = 2; end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        m_inst  = mem[m_pc[9:2]];
        m_pcout = m_pc;
      end
    end else if (m_valid) begin
      if (rd) begin m_valid = 1'b0; m_await = 1'b1; end
    end else if (m_await && nv) begin
      m_await = 1'b0;
      if (n[1:0] == 2'b00) begin
        m_pc = n; m_ret = m_ret + 32'd1; m_cnt = 2;
      end else begin
        m_err = 1'b1; m_halt = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, clock, advance the model, compare after the edge.
  task automatic step(input logic r, s, rd, nv, input logic [9:0] n);
    rstn = r; start = s; inst_ready = rd; npc_valid = nv; npc = n;
    @(posedge clk);
    cyc++;
    model_update(r, s, rd, nv, n);
    #1;
    check("m_imem_addr",  imem_addr,  m_pc[9:2]);
    check("m_inst_valid", inst_valid, m_valid);
    check("m_inst",       inst,       m_inst);
    check("m_pc_out",     pc_out,     m_pcout);
    check("m_retired",    retired,    m_ret);
    check("m_err",        err,        m_err);
  endtask

  task automatic run_to_valid(input logic s, nv, input logic [9:0] n);
    for (int i = 0; i < 8 && !m_valid; i++) step(1'b1, s, 1'b0, nv, n);
    check("reach_valid", inst_valid, 1'b1);
  endtask

  task automatic accept_redirect(input logic [9:0] n);
    step(1'b1, 1'b0, 1'b1, 1'b0, 10'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, n);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        rstn, start, ready, nv;
    logic [9:0]  npc;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [9:0]  e_pcout;
    logic [7:0]  e_addr;
    logic [31:0] e_ret;
    logic        e_err;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] i0, i15;
    int          last_rise;
    int          n_rise;
    logic        prev_v;

    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0107);
    mem[0] = 32'h2001_0005;
    i0  = mem[0];
    i15 = mem[15];
    rstn = 1'b0; start = 1'b0; inst_ready = 1'b0; npc_valid = 1'b0; npc = '0;

    // Reset, start, backpressure, redirect to 0x3C, misaligned npc, reset.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 32'd0, 10'h000, 8'h00, 32'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 32'd0, 10'h000, 8'h00, 32'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 32'd0, 10'h000, 8'h00, 32'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, i0,    10'h000, 8'h00, 32'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, i0,    10'h000, 8'h00, 32'd0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, i0,    10'h000, 8'h00, 32'd0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 10'h03C, 1'b0, i0,    10'h000, 8'h0F, 32'd1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, i0,    10'h000, 8'h0F, 32'd1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, i15,   10'h03C, 8'h0F, 32'd1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, i15,   10'h03C, 8'h0F, 32'd1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 10'h012, 1'b0, i15,   10'h03C, 8'h0F, 32'd1, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'h040, 1'b0, i15,   10'h03C, 8'h0F, 32'd1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 32'd0, 10'h000, 8'h00, 32'd0, 1'b0};

    for (int v = 0; v < 13; v++) begin
      step(vecs[v].rstn, vecs[v].start, vecs[v].ready, vecs[v].nv, vecs[v].npc);
      check($sformatf("vec%0d_valid", v),   inst_valid, vecs[v].e_valid);
      check($sformatf("vec%0d_inst", v),    inst,       vecs[v].e_inst);
      check($sformatf("vec%0d_pc_out", v),  pc_out,     vecs[v].e_pcout);
      check($sformatf("vec%0d_addr", v),    imem_addr,  vecs[v].e_addr);
      check($sformatf("vec%0d_retired", v), retired,    vecs[v].e_ret);
      check($sformatf("vec%0d_err", v),     err,        vecs[v].e_err);
    end

    // Sequential flow: ready tied high from before valid rises, npc = pc+4.
    step(1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
    last_rise = -1; n_rise = 0; prev_v = 1'b0;
    for (int i = 0; i < 100 && m_ret < 32'd8; i++) begin
      step(1'b1, 1'b0, 1'b1, m_await, m_pcout + 10'd4);
      if (inst_valid && !prev_v) begin
        check("seq_pc_out", pc_out, 10'(n_rise * 4));
        check("seq_inst",   inst,   mem[n_rise]);
        if (last_rise >= 0) check("seq_period", cyc - last_rise, 4);
        last_rise = cyc;
        n_rise++;
      end
      prev_v = inst_valid;
    end
    check("seq_retired", retired, 32'd8);

    // Ignored npc_valid/start during FETCH and WAIT, then 5 cycles backpressure.
    run_to_valid(1'b1, 1'b1, 10'h080);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i[0], 1'b0, 1'b1, 10'h080);
      check("bp_pc_out", pc_out, 10'd32);
      check("bp_inst",   inst,   mem[8]);
      check("bp_addr",   imem_addr, 8'd8);
      check("bp_ret",    retired, 32'd8);
    end
    accept_redirect(10'h03C);
    check("redir_addr", imem_addr, 8'h0F);
    run_to_valid(1'b0, 1'b0, 10'd0);
    check("redir_pc_out", pc_out, 10'h03C);
    check("redir_inst",   inst,   mem[15]);

    // Wrap: top word then word 0.
    accept_redirect(10'h3FC);
    run_to_valid(1'b0, 1'b0, 10'd0);
    check("wrap_hi_pc", pc_out, 10'h3FC);
    check("wrap_hi_inst", inst, mem[255]);
    accept_redirect(10'h000);
    run_to_valid(1'b0, 1'b0, 10'd0);
    check("wrap_lo_pc", pc_out, 10'h000);
    check("wrap_lo_inst", inst, mem[0]);

    // Reset while in WAIT: nothing from the in-flight read may surface.
    accept_redirect(10'h004);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    check("rst_wait_valid", inst_valid, 1'b0);
    check("rst_wait_inst",  inst,       32'd0);
    check("rst_wait_pc",    pc_out,     10'd0);
    check("rst_wait_ret",   retired,    32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 10'd0);
    check("rst_wait_idle",  inst_valid, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic       r, s, rd, nv;
      logic [9:0] n;
      r  = m_halt ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 299) != 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = $urandom_range(0, 1) == 1;
      nv = $urandom_range(0, 1) == 1;
      n  = 10'($urandom);
      if ($urandom_range(0, 15) != 0) n[1:0] = 2'b00;
      step(r, s, rd, nv, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
